// File: rtl/net_access_controller.sv
// Sequences MEM-stage NET_WRITE / NET_READ against the NoC network interface.
// Converts a single-cycle request into a valid/ready handshake and stalls the pipeline meanwhile.
module net_access_controller #(
    parameter int unsigned DEST_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  MEM_NET_WRITE,
    input  logic                  MEM_NET_READ,
    input  logic [31:0]           MEM_ALU_OUT,
    input  logic [31:0]           MEM_REG_DATA2,
    input  logic                  ERR_CLEAR,
    input  logic                  NI_TX_READY,
    input  logic                  NI_RX_VALID,
    input  logic [31:0]           NI_RX_DATA,
    output logic                  NI_TX_VALID,
    output logic [31:0]           NI_TX_DATA,
    output logic [DEST_WIDTH-1:0] NI_TX_DEST,
    output logic                  NI_RX_READY,
    output logic [31:0]           NET_READ_DATA,
    output logic                  PIPELINE_STALL,
    output logic                  NET_ERROR
);

    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TMAX_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TMAX_I);

    typedef enum logic [1:0] {StIdle, StSend, StRecv, StDone} state_e;

    state_e                r_state, w_state_d;
    logic                  r_tx_valid, w_tx_valid_d;
    logic                  r_rx_ready, w_rx_ready_d;
    logic [31:0]           r_tx_data, w_tx_data_d;
    logic [DEST_WIDTH-1:0] r_tx_dest, w_tx_dest_d;
    logic [31:0]           r_rd_data, w_rd_data_d;
    logic [CNT_W-1:0]      r_cnt, w_cnt_d;
    logic                  r_err;
    logic                  w_err_set;
    logic                  w_timeout;
    logic                  w_unused_addr;

    assign w_unused_addr = ^MEM_ALU_OUT[31:DEST_WIDTH];

    // Timeout fires on the last allowed cycle; a handshake on that same cycle still wins.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_MAX);

    always_comb begin
        w_state_d    = r_state;
        w_tx_valid_d = r_tx_valid;
        w_rx_ready_d = r_rx_ready;
        w_tx_data_d  = r_tx_data;
        w_tx_dest_d  = r_tx_dest;
        w_rd_data_d  = r_rd_data;
        w_cnt_d      = r_cnt;
        w_err_set    = 1'b0;
        case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                if (MEM_NET_WRITE) begin
                    w_tx_data_d  = MEM_REG_DATA2;
                    w_tx_dest_d  = MEM_ALU_OUT[DEST_WIDTH-1:0];
                    w_tx_valid_d = 1'b1;
                    w_state_d    = StSend;
                    w_err_set    = MEM_NET_READ;
                end else if (MEM_NET_READ) begin
                    w_rx_ready_d = 1'b1;
                    w_state_d    = StRecv;
                end
            end
            StSend: begin
                if (NI_TX_READY || w_timeout) begin
                    w_tx_valid_d = 1'b0;
                    w_cnt_d      = '0;
                    w_state_d    = StDone;
                    w_err_set    = !NI_TX_READY;
                end else if (TIMEOUT_CYCLES != 0) begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            StRecv: begin
                if (NI_RX_VALID || w_timeout) begin
                    w_rx_ready_d = 1'b0;
                    w_cnt_d      = '0;
                    w_state_d    = StDone;
                    w_rd_data_d  = NI_RX_VALID ? NI_RX_DATA : 32'h0;
                    w_err_set    = !NI_RX_VALID;
                end else if (TIMEOUT_CYCLES != 0) begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d    = StIdle;
                w_tx_valid_d = 1'b0;
                w_rx_ready_d = 1'b0;
                w_cnt_d      = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= StIdle;
            r_tx_valid <= 1'b0;
            r_rx_ready <= 1'b0;
            r_tx_data  <= '0;
            r_tx_dest  <= '0;
            r_rd_data  <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_tx_valid <= w_tx_valid_d;
            r_rx_ready <= w_rx_ready_d;
            r_tx_data  <= w_tx_data_d;
            r_tx_dest  <= w_tx_dest_d;
            r_rd_data  <= w_rd_data_d;
            r_cnt      <= w_cnt_d;
            // Set has priority over a simultaneous clear.
            r_err      <= w_err_set | (r_err & ~ERR_CLEAR);
        end
    end

    always_comb begin
        PIPELINE_STALL = 1'b0;
        case (r_state)
            StIdle:         PIPELINE_STALL = MEM_NET_WRITE | MEM_NET_READ;
            StSend, StRecv: PIPELINE_STALL = 1'b1;
            default:        PIPELINE_STALL = 1'b0;
        endcase
    end

    assign NI_TX_VALID   = r_tx_valid;
    assign NI_TX_DATA    = r_tx_data;
    assign NI_TX_DEST    = r_tx_dest;
    assign NI_RX_READY   = r_rx_ready;
    assign NET_READ_DATA = r_rd_data;
    assign NET_ERROR     = r_err;

endmodule

// File: tb/tb_net_access_controller.sv
// Directed bench for net_access_controller: per-cycle vector table plus hand-written
// timeout and reset-abort sequences.
module tb_net_access_controller;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_NET_WRITE, MEM_NET_READ;
    logic [31:0] MEM_ALU_OUT, MEM_REG_DATA2;
    logic        ERR_CLEAR, NI_TX_READY, NI_RX_VALID;
    logic [31:0] NI_RX_DATA;
    logic        NI_TX_VALID;
    logic [31:0] NI_TX_DATA;
    logic [7:0]  NI_TX_DEST;
    logic        NI_RX_READY;
    logic [31:0] NET_READ_DATA;
    logic        PIPELINE_STALL, NET_ERROR;

    int n_checks = 0;
    int n_fail   = 0;
    int n_tx     = 0;
    int n_rx     = 0;

    net_access_controller #(.DEST_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .MEM_NET_WRITE  (MEM_NET_WRITE),
        .MEM_NET_READ   (MEM_NET_READ),
        .MEM_ALU_OUT    (MEM_ALU_OUT),
        .MEM_REG_DATA2  (MEM_REG_DATA2),
        .ERR_CLEAR      (ERR_CLEAR),
        .NI_TX_READY    (NI_TX_READY),
        .NI_RX_VALID    (NI_RX_VALID),
        .NI_RX_DATA     (NI_RX_DATA),
        .NI_TX_VALID    (NI_TX_VALID),
        .NI_TX_DATA     (NI_TX_DATA),
        .NI_TX_DEST     (NI_TX_DEST),
        .NI_RX_READY    (NI_RX_READY),
        .NET_READ_DATA  (NET_READ_DATA),
        .PIPELINE_STALL (PIPELINE_STALL),
        .NET_ERROR      (NET_ERROR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (!RESET && NI_TX_VALID && NI_TX_READY) n_tx <= n_tx + 1;
        if (!RESET && NI_RX_READY && NI_RX_VALID) n_rx <= n_rx + 1;
    end

    typedef struct {
        logic        w, r;
        logic [31:0] alu, d2;
        logic        clr, txr, rxv;
        logic [31:0] rxd;
        logic        e_txv;
        logic [31:0] e_txd;
        logic [7:0]  e_dest;
        logic        e_rxr;
        logic [31:0] e_rd;
        logic        e_stall, e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic w, logic r, logic [31:0] alu, logic [31:0] d2,
                                logic clr, logic txr, logic rxv, logic [31:0] rxd,
                                logic txv, logic [31:0] txd, logic [7:0] dest, logic rxr,
                                logic [31:0] rd, logic stall, logic err);
        vec_t v;
        v.w = w; v.r = r; v.alu = alu; v.d2 = d2; v.clr = clr; v.txr = txr; v.rxv = rxv;
        v.rxd = rxd; v.e_txv = txv; v.e_txd = txd; v.e_dest = dest; v.e_rxr = rxr;
        v.e_rd = rd; v.e_stall = stall; v.e_err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_idle_reset_values(input string tag);
        check({tag, " tx_valid"}, {31'b0, NI_TX_VALID}, 32'd0);
        check({tag, " tx_data"}, NI_TX_DATA, 32'd0);
        check({tag, " tx_dest"}, {24'b0, NI_TX_DEST}, 32'd0);
        check({tag, " rx_ready"}, {31'b0, NI_RX_READY}, 32'd0);
        check({tag, " read_data"}, NET_READ_DATA, 32'd0);
        check({tag, " stall"}, {31'b0, PIPELINE_STALL}, 32'd0);
        check({tag, " error"}, {31'b0, NET_ERROR}, 32'd0);
    endtask

    initial begin
        int cnt;
        int tx0;
        RESET = 1'b1; MEM_NET_WRITE = 0; MEM_NET_READ = 0; MEM_ALU_OUT = 0; MEM_REG_DATA2 = 0;
        ERR_CLEAR = 0; NI_TX_READY = 0; NI_RX_VALID = 0; NI_RX_DATA = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1 check_idle_reset_values("reset");

        // Single send, read with 5 wait cycles, back-to-back write/read, write+read conflict.
        vecs.push_back(mk(1,0,32'h123,32'hDEADBEEF,0,1,0,32'hCAFE0001, 0,32'h0,8'h00,0,32'h0,1,0));
        vecs.push_back(mk(1,0,32'h123,32'hDEADBEEF,0,1,0,32'hCAFE0001, 1,32'hDEADBEEF,8'h23,0,32'h0,1,0));
        vecs.push_back(mk(1,0,32'h123,32'hDEADBEEF,0,1,0,32'hCAFE0001, 0,32'hDEADBEEF,8'h23,0,32'h0,0,0));
        vecs.push_back(mk(0,0,32'h0,32'h0,0,1,0,32'hCAFE0001, 0,32'hDEADBEEF,8'h23,0,32'h0,0,0));
        vecs.push_back(mk(0,1,32'h0,32'h0,0,1,0,32'hCAFE0001, 0,32'hDEADBEEF,8'h23,0,32'h0,1,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,1,32'h0,32'h0,0,1,0,32'hCAFE0001, 0,32'hDEADBEEF,8'h23,1,32'h0,1,0));
        vecs.push_back(mk(0,1,32'h0,32'h0,0,1,1,32'hCAFE0001, 0,32'hDEADBEEF,8'h23,1,32'h0,1,0));
        vecs.push_back(mk(0,1,32'h0,32'h0,0,1,0,32'hCAFE0001, 0,32'hDEADBEEF,8'h23,0,32'hCAFE0001,0,0));
        vecs.push_back(mk(0,0,32'h0,32'h0,0,1,0,32'hCAFE0001, 0,32'hDEADBEEF,8'h23,0,32'hCAFE0001,0,0));
        vecs.push_back(mk(1,0,32'hA5,32'h11112222,0,1,1,32'h12345678, 0,32'hDEADBEEF,8'h23,0,32'hCAFE0001,1,0));
        vecs.push_back(mk(1,0,32'hA5,32'h11112222,0,1,1,32'h12345678, 1,32'h11112222,8'hA5,0,32'hCAFE0001,1,0));
        vecs.push_back(mk(1,0,32'hA5,32'h11112222,0,1,1,32'h12345678, 0,32'h11112222,8'hA5,0,32'hCAFE0001,0,0));
        vecs.push_back(mk(0,1,32'h0,32'h0,0,1,1,32'h12345678, 0,32'h11112222,8'hA5,0,32'hCAFE0001,1,0));
        vecs.push_back(mk(0,1,32'h0,32'h0,0,1,1,32'h12345678, 0,32'h11112222,8'hA5,1,32'hCAFE0001,1,0));
        vecs.push_back(mk(0,1,32'h0,32'h0,0,1,1,32'h12345678, 0,32'h11112222,8'hA5,0,32'h12345678,0,0));
        vecs.push_back(mk(0,0,32'h0,32'h0,0,1,0,32'h12345678, 0,32'h11112222,8'hA5,0,32'h12345678,0,0));
        vecs.push_back(mk(1,1,32'h1FF,32'h0BADF00D,0,1,0,32'h0, 0,32'h11112222,8'hA5,0,32'h12345678,1,0));
        vecs.push_back(mk(1,1,32'h1FF,32'h0BADF00D,0,1,0,32'h0, 1,32'h0BADF00D,8'hFF,0,32'h12345678,1,1));
        vecs.push_back(mk(1,1,32'h1FF,32'h0BADF00D,0,1,0,32'h0, 0,32'h0BADF00D,8'hFF,0,32'h12345678,0,1));
        vecs.push_back(mk(0,0,32'h0,32'h0,1,1,0,32'h0, 0,32'h0BADF00D,8'hFF,0,32'h12345678,0,1));
        vecs.push_back(mk(0,0,32'h0,32'h0,0,1,0,32'h0, 0,32'h0BADF00D,8'hFF,0,32'h12345678,0,0));

        foreach (vecs[i]) begin
            @(negedge CLK);
            MEM_NET_WRITE = vecs[i].w;   MEM_NET_READ  = vecs[i].r;
            MEM_ALU_OUT   = vecs[i].alu; MEM_REG_DATA2 = vecs[i].d2;
            ERR_CLEAR     = vecs[i].clr; NI_TX_READY   = vecs[i].txr;
            NI_RX_VALID   = vecs[i].rxv; NI_RX_DATA    = vecs[i].rxd;
            #1;
            check($sformatf("v%0d tx_valid", i), {31'b0, NI_TX_VALID}, {31'b0, vecs[i].e_txv});
            check($sformatf("v%0d tx_data", i), NI_TX_DATA, vecs[i].e_txd);
            check($sformatf("v%0d tx_dest", i), {24'b0, NI_TX_DEST}, {24'b0, vecs[i].e_dest});
            check($sformatf("v%0d rx_ready", i), {31'b0, NI_RX_READY}, {31'b0, vecs[i].e_rxr});
            check($sformatf("v%0d read_data", i), NET_READ_DATA, vecs[i].e_rd);
            check($sformatf("v%0d stall", i), {31'b0, PIPELINE_STALL}, {31'b0, vecs[i].e_stall});
            check($sformatf("v%0d error", i), {31'b0, NET_ERROR}, {31'b0, vecs[i].e_err});
        end
        check("table tx handshakes", n_tx, 3);
        check("table rx handshakes", n_rx, 2);

        // Send timeout; ERR_CLEAR held during SEND so the final set collides with a clear.
        tx0 = n_tx;
        @(negedge CLK);
        MEM_NET_WRITE = 1; MEM_ALU_OUT = 32'h42; MEM_REG_DATA2 = 32'h55AA55AA;
        NI_TX_READY = 0; NI_RX_VALID = 0;
        #1 check("to idle stall", {31'b0, PIPELINE_STALL}, 32'd1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            #1;
            if (!NI_TX_VALID) break;
            if (cnt == 0) begin
                check("to tx_data", NI_TX_DATA, 32'h55AA55AA);
                check("to tx_dest", {24'b0, NI_TX_DEST}, 32'h42);
            end
            cnt++;
            ERR_CLEAR = 1;
        end
        check("to valid cycles", cnt, 16);
        check("to done error", {31'b0, NET_ERROR}, 32'd1);
        check("to done stall", {31'b0, PIPELINE_STALL}, 32'd0);
        ERR_CLEAR = 0; MEM_NET_WRITE = 0;
        @(negedge CLK);
        #1 check("to error sticky", {31'b0, NET_ERROR}, 32'd1);
        check("to no handshake", n_tx, tx0);
        ERR_CLEAR = 1;
        @(negedge CLK);
        ERR_CLEAR = 0;
        #1 check("to error cleared", {31'b0, NET_ERROR}, 32'd0);

        // Read timeout overwrites the previous word with zero.
        MEM_NET_READ = 1; NI_RX_VALID = 0; NI_RX_DATA = 32'hFFFF0000;
        cnt = 0;
        @(negedge CLK);
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!NI_RX_READY) break;
            cnt++;
            @(negedge CLK);
        end
        check("rto ready cycles", cnt, 16);
        check("rto read_data", NET_READ_DATA, 32'h0);
        check("rto error", {31'b0, NET_ERROR}, 32'd1);
        MEM_NET_READ = 0; ERR_CLEAR = 1;
        @(negedge CLK);
        ERR_CLEAR = 0;

        // Reset during SEND, then a fresh send.
        tx0 = n_tx;
        @(negedge CLK);
        MEM_NET_WRITE = 1; MEM_ALU_OUT = 32'h77; MEM_REG_DATA2 = 32'h77777777; NI_TX_READY = 0;
        @(negedge CLK);
        #1 check("rst in send valid", {31'b0, NI_TX_VALID}, 32'd1);
        RESET = 1; MEM_NET_WRITE = 0;
        @(negedge CLK);
        #1 check_idle_reset_values("rst abort");
        check("rst no handshake", n_tx, tx0);
        RESET = 0;
        @(negedge CLK);
        MEM_NET_WRITE = 1; MEM_ALU_OUT = 32'h3C; MEM_REG_DATA2 = 32'hA5A5F00F; NI_TX_READY = 1;
        @(negedge CLK);
        #1 check("fresh valid", {31'b0, NI_TX_VALID}, 32'd1);
        check("fresh data", NI_TX_DATA, 32'hA5A5F00F);
        check("fresh dest", {24'b0, NI_TX_DEST}, 32'h3C);
        @(negedge CLK);
        #1 check("fresh done stall", {31'b0, PIPELINE_STALL}, 32'd0);
        MEM_NET_WRITE = 0;
        @(negedge CLK);
        check("fresh one handshake", n_tx, tx0 + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
